usb_tx_arbiter: RTL
===================

Name: usb_tx_arbiter

Overview:
- Shares the single USB-serial transmit pipe (uart_in_data/valid/ready into usb_uart) between NUM_REQ independent byte-stream requesters, e.g. banner generator, loopback echo, status reporter.
- Arbitration is frame-atomic round-robin: a requester holds the pipe until it delivers a byte flagged last, so messages never interleave.
- Sits in top between the requesters and usb_uart, in the clk_48mhz domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, idle cycles mid-frame before forced release (optional feature only).

Ports:
- clk_48mhz  input  1  system clock, 48 MHz
- reset_n  input  1  asynchronous, active-low reset
- req_data  input  8*NUM_REQ  byte from requester i in bits [8i+7:8i]
- req_valid  input  NUM_REQ  requester i byte valid
- req_last  input  NUM_REQ  requester i byte ends its frame
- req_ready  output  NUM_REQ  requester i byte accepted this cycle when valid&ready
- uart_in_data  output  8  byte to usb_uart
- uart_in_valid  output  1  byte valid to usb_uart
- uart_in_ready  input  1  usb_uart accepts byte
- grant_id  output  clog2(NUM_REQ)  current or most recent grant owner
- busy  output  1  a frame is in progress (state GRANT)
- frame_abort  output  1  one-cycle pulse on timeout release (optional feature only, else tied 0)

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, uart_in_valid=0, uart_in_data=0, req_ready=0, grant_id=0, busy=0, frame_abort=0, rr_ptr=NUM_REQ-1 so requester 0 wins first. Asserting reset mid-frame discards any held output byte and the partial frame. No recovery framing is sent.
- States: IDLE, GRANT.
- IDLE: if any req_valid, select the first set bit searching rr_ptr+1, rr_ptr+2, … with modulo NUM_REQ wrap. Register grant_id, go to GRANT, busy=1. Arbitration costs exactly 1 cycle. req_ready is all-zero in IDLE.
- GRANT:
  - req_ready[grant_id] = ~uart_in_valid | uart_in_ready. All other req_ready are 0. This is combinational from registered state plus uart_in_ready.
  - On req_valid&req_ready for the owner, the byte is loaded into the output register and uart_in_valid=1 next cycle. Throughput is 1 byte/cycle while uart_in_ready stays high.
  - When the accepted byte has req_last=1: go to IDLE, rr_ptr=grant_id, busy=0. The output register still drains normally.
- Output register rules:
  - uart_in_valid and uart_in_data stay stable until uart_in_ready.
  - uart_in_valid drops only after a transfer with no new load.
  - uart_in_valid never rises in the cycle after reset release.
- Simultaneous events:
  - Last byte accepted while other requesters are valid: at least one IDLE bubble cycle, then a grant to the next in round-robin order.
  - A requester deasserting valid mid-frame keeps the grant; without the optional feature the grant is held indefinitely.
  - Owner valid in the same cycle its frame ends: no effect; it cannot win again until the other valid requesters are served.
- Single-byte frame (valid&last together) is legal. grant_id keeps its value in IDLE.

Optional Feature:
- Macro: USB_TX_ARB_TIMEOUT_EN.
- With the macro: a counter (clog2(TIMEOUT_CYCLES)+1 bits) counts GRANT cycles where the owner's req_valid=0. It clears on any accepted byte and on entry to GRANT.
  - At TIMEOUT_CYCLES: go to IDLE, rr_ptr=grant_id, frame_abort pulses high for 1 cycle.
  - A byte already in the output register still drains.
- Without the macro: no counter, frame_abort tied 0, grant held until last.

Decomposition:
- Shared package usb_tx_pkg: state encoding (ARB_IDLE=0, ARB_GRANT=1), byte width constant USB_BYTE_W=8.
- One natural sub-module: rr_pick, a combinational round-robin first-one finder with inputs req mask and rr_ptr, outputs index and any.
- Everything else stays in usb_tx_arbiter.

Test Plan:
- Reset priority: req 0 and req 2 both valid with 3-byte frames "ab\n" and "xy\n", uart_in_ready=1 → uart_in_data sequence a,b,\n,x,y,\n; one bubble cycle between frames; grant_id 0 then 2.
- Fairness: all 4 requesters continuously valid with 1-byte last frames → grants 0,1,2,3,0,… and each requester gets exactly 25 bytes out of 100 frames.
- Backpressure: uart_in_ready toggling 1,0,0,1 during a 14-byte "Hello World!\r\n" frame → output bytes unchanged while stalled; the received string is bit-exact; req_ready low whenever uart_in_valid&~uart_in_ready.
- Atomicity: req 1 valid starts mid-way through req 0's 5-byte frame → no req 1 byte appears before req 0's last byte; req_ready[1]=0 throughout.
- Reset mid-frame: reset_n pulsed low after byte 2 of a 6-byte frame → all outputs zero immediately (asynchronous); after release the next grant goes to requester 0 if valid.
- Timeout (USB_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): owner sends 2 bytes, then valid=0 → frame_abort pulses at idle cycle 16; the next valid requester is granted 1 cycle after the pulse.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit arbiter.
package usb_tx_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int USB_BYTE_W = 8;

endpackage

// File: rtl/usb_tx_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: searches ptr+1, ptr+2, ... modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    int unsigned j;

    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                idx = j[W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing the usb_uart transmit pipe between requesters.
// Define USB_TX_ARB_TIMEOUT_EN to release a stalled owner after TIMEOUT_CYCLES idle cycles.
//
// state     | meaning
// ARB_IDLE  | no owner; pick next valid requester after rr_ptr (one cycle)
// ARB_GRANT | grant_id owns the pipe until it delivers a byte flagged last
module usb_tx_arbiter
    import usb_tx_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                          clk_48mhz,
    input  logic                          reset_n,
    input  logic [USB_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [USB_BYTE_W-1:0]         uart_in_data,
    output logic                          uart_in_valid,
    input  logic                          uart_in_ready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          frame_abort
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("usb_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    arb_state_t            state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       pick_idx;
    logic                  pick_any;
    logic                  owner_valid;
    logic                  owner_last;
    logic                  owner_ready;
    logic [USB_BYTE_W-1:0] owner_data;
    logic                  accept;
    logic                  timeout;

    rr_pick #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_valid = req_valid[grant_id];
    assign owner_last  = req_last[grant_id];
    assign owner_data  = req_data[grant_id*USB_BYTE_W +: USB_BYTE_W];
    // Owner may load whenever the output register is empty or draining this cycle.
    assign owner_ready = (state == ARB_GRANT) && (!uart_in_valid || uart_in_ready);
    assign accept      = owner_valid && owner_ready;

    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = owner_ready;
    end

`ifdef USB_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] idle_cnt;

    assign timeout = (state == ARB_GRANT) && !owner_valid
                     && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (state == ARB_IDLE || accept) begin
            idle_cnt <= '0;
        end else if (!owner_valid) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ARB_IDLE;
            grant_id    <= '0;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            busy        <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        state    <= ARB_GRANT;
                        busy     <= 1'b1;
                    end
                end
                ARB_GRANT: begin
                    if ((accept && owner_last) || timeout) begin
                        state       <= ARB_IDLE;
                        rr_ptr      <= grant_id;
                        busy        <= 1'b0;
                        frame_abort <= timeout;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Output byte holds until usb_uart takes it; it drains even after the frame ends.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            uart_in_valid <= 1'b0;
            uart_in_data  <= '0;
        end else if (accept) begin
            uart_in_valid <= 1'b1;
            uart_in_data  <= owner_data;
        end else if (uart_in_ready) begin
            uart_in_valid <= 1'b0;
        end
    end

endmodule
